address_averager: RTL and testbench
===================================

ADDRESS_AVERAGER -- requirements
Module: address_averager

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning log2 of BRAM depth in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 14, meaning signed ADC sample width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, meaning accumulator and BRAM word width.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: addr  in  WIDTH+2  byte address from address generator; tvalid  in  1  addr/din valid; restart  in  1  one-cycle pulse on first address of each period.
REQ-006 SHALL have ports: din  in  DATA_WIDTH  signed sample aligned with addr; start  in  1  one-cycle arm pulse; n_avg_min  in  32  periods to accumulate.
REQ-007 SHALL have ports: bram_raddr  out  WIDTH  read word index; bram_rdata  in  ACC_WIDTH  read data, latency 2.
REQ-008 SHALL have ports: bram_wen  out  1; bram_waddr  out  WIDTH; bram_wdata  out  ACC_WIDTH.
REQ-009 SHALL have ports: n_avg  out  32  completed periods; ready  out  1  result complete.

Function
REQ-010 SHALL drive bram_raddr = addr[WIDTH+1:2] combinationally, no latency.
REQ-011 SHALL, for accepted sample in cycle t (tvalid=1, state RUN), assert bram_wen with waddr = that word index in cycle t+3.
REQ-012 SHALL compute bram_wdata = sign-extended din on first period, else bram_rdata (sampled t+2) + sign-extended din, wrapping modulo 2^ACC_WIDTH.
REQ-013 SHALL implement states IDLE, ARMED, RUN, DRAIN, DONE.
REQ-014 SHALL go IDLE->ARMED on start; ARMED->RUN on restart, that cycle being first sample of first period.
REQ-015 SHALL, on restart in RUN, increment n_avg; if new n_avg >= n_avg_min, go to DRAIN, restart-cycle sample not accepted.
REQ-016 SHALL stay in DRAIN 3 cycles, completing in-flight writes, then enter DONE; ready=1 only in DONE.
REQ-017 SHALL on start in any state clear n_avg, ready, first-period flag; go ARMED; in-flight writes still complete.
REQ-018 SHALL ignore restart and tvalid in IDLE, ARMED (except arm transition), DONE.
REQ-019 SHALL treat n_avg_min=0 as 1.
REQ-020 SHALL hold bram_wen=0 in cycles with no accepted sample 3 cycles earlier.
REQ-021 SHALL saturate n_avg at 2^32-1.

Reset
REQ-022 SHALL on rst_n=0 immediately set state IDLE, n_avg=0, ready=0, bram_wen=0, bram_waddr=0, bram_wdata=0, pipeline valids=0.
REQ-023 SHALL discard in-flight samples when reset asserts mid-operation; no write after release.

Configuration
REQ-024 SHALL, with ADDRESS_AVERAGER_FORWARD_EN defined, forward pending write data (stages t+2, t+3) to read operand on word-index match, correct for any period >= 1 word.
REQ-025 SHALL, without ADDRESS_AVERAGER_FORWARD_EN, omit forwarding; correct only for period >= 4 words; shorter periods unsupported, results undefined.

Verification
REQ-026 WIDTH=8, period 256 words, din=5, n_avg_min=4, start then restarts -> every word reads 20, n_avg=4, ready high 4 cycles after 5th restart.
REQ-027 Alternating din=+3/-3 by period, n_avg_min=2 -> all words 0; din=-1 one period -> words 0xFFFFFFFF.
REQ-028 Accumulator 0xFFFFFFF0 region, din=0x20 -> wraps to 0x00000010, no flag.
REQ-029 start mid-RUN at n_avg=2 -> n_avg=0 next cycle, ARMED, next period overwrites (not adds).
REQ-030 rst_n low during RUN with writes pending -> bram_wen=0 same cycle, all outputs reset, no write after release.
REQ-031 FORWARD_EN defined, period 2 words, din=1, n_avg_min=8 -> both words 8; undefined, 2-word test excluded.

Source files
------------

// File: rtl/address_averager.sv
// Accumulates signed samples into a word-addressed BRAM over n_avg_min periods; read-modify-write, write 3 cycles after accept.
// No backpressure: samples are accepted whenever tvalid is high in RUN. ready marks a finished result.
// Optional ADDRESS_AVERAGER_FORWARD_EN forwards the two most recent writes so periods shorter than 4 words stay correct.
module address_averager #(
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 14,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH+1:0]      addr,
    input  logic                  tvalid,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    input  logic [31:0]           n_avg_min,
    output logic [WIDTH-1:0]      bram_raddr,
    input  logic [ACC_WIDTH-1:0]  bram_rdata,
    output logic                  bram_wen,
    output logic [WIDTH-1:0]      bram_waddr,
    output logic [ACC_WIDTH-1:0]  bram_wdata,
    output logic [31:0]           n_avg,
    output logic                  ready
);

    typedef enum logic [2:0] {IDLE, ARMED, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            drain_cnt_q, drain_cnt_d;
    logic [31:0]           n_avg_q, n_avg_d;
    logic                  first_q, first_d;
    logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0]      s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic [DATA_WIDTH-1:0] s1_din_q, s1_din_d, s2_din_q, s2_din_d;
    logic                  s1_first_q, s1_first_d, s2_first_q, s2_first_d;
    logic                  wen_q, wen_d;
    logic [WIDTH-1:0]      waddr_q, waddr_d;
    logic [ACC_WIDTH-1:0]  wdata_q, wdata_d;
`ifdef ADDRESS_AVERAGER_FORWARD_EN
    logic                  hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0]      hold_idx_q, hold_idx_d;
    logic [ACC_WIDTH-1:0]  hold_dat_q, hold_dat_d;
`endif

    logic                  acc_vld;
    logic [31:0]           n_avg_inc;
    logic [31:0]           n_target;
    logic [ACC_WIDTH-1:0]  din_ext;
    logic [ACC_WIDTH-1:0]  operand;
    logic                  unused_addr_lsbs;

    assign bram_raddr       = addr[WIDTH+1:2];
    assign unused_addr_lsbs = ^addr[1:0];
    assign bram_wen         = wen_q;
    assign bram_waddr       = waddr_q;
    assign bram_wdata       = wdata_q;
    assign n_avg            = n_avg_q;
    assign ready            = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        n_avg_d     = n_avg_q;
        first_d     = first_q;
        acc_vld     = 1'b0;
        n_avg_inc   = (n_avg_q == '1) ? n_avg_q : n_avg_q + 32'd1;
        n_target    = (n_avg_min == '0) ? 32'd1 : n_avg_min;
        if (start) begin
            state_d     = ARMED;
            n_avg_d     = '0;
            first_d     = 1'b1;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (restart) begin
                        state_d = RUN;
                        first_d = 1'b1;
                        acc_vld = tvalid;
                    end
                end
                RUN: begin
                    if (restart) begin
                        n_avg_d = n_avg_inc;
                        first_d = 1'b0;
                        if (n_avg_inc >= n_target) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end else begin
                            acc_vld = tvalid;
                        end
                    end else begin
                        acc_vld = tvalid;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 2'd2) state_d = DONE;
                    else drain_cnt_d = drain_cnt_q + 2'd1;
                end
                IDLE, DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        s1_vld_d   = acc_vld;
        s1_idx_d   = bram_raddr;
        s1_din_d   = din;
        s1_first_d = first_d;
        s2_vld_d   = s1_vld_q;
        s2_idx_d   = s1_idx_q;
        s2_din_d   = s1_din_q;
        s2_first_d = s1_first_q;
        din_ext    = {{(ACC_WIDTH-DATA_WIDTH){s2_din_q[DATA_WIDTH-1]}}, s2_din_q};
        operand    = bram_rdata;
`ifdef ADDRESS_AVERAGER_FORWARD_EN
        // The read missed the write now on the port and the one just before it; newest wins.
        if (wen_q && (waddr_q == s2_idx_q))
            operand = wdata_q;
        else if (hold_vld_q && (hold_idx_q == s2_idx_q))
            operand = hold_dat_q;
        hold_vld_d = wen_q;
        hold_idx_d = waddr_q;
        hold_dat_d = wdata_q;
`endif
        wen_d   = s2_vld_q;
        waddr_d = s2_vld_q ? s2_idx_q : waddr_q;
        wdata_d = wdata_q;
        if (s2_vld_q) wdata_d = s2_first_q ? din_ext : operand + din_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            n_avg_q     <= '0;
            first_q     <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_din_q    <= '0;
            s1_first_q  <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_din_q    <= '0;
            s2_first_q  <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
`ifdef ADDRESS_AVERAGER_FORWARD_EN
            hold_vld_q  <= 1'b0;
            hold_idx_q  <= '0;
            hold_dat_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            n_avg_q     <= n_avg_d;
            first_q     <= first_d;
            s1_vld_q    <= s1_vld_d;
            s1_idx_q    <= s1_idx_d;
            s1_din_q    <= s1_din_d;
            s1_first_q  <= s1_first_d;
            s2_vld_q    <= s2_vld_d;
            s2_idx_q    <= s2_idx_d;
            s2_din_q    <= s2_din_d;
            s2_first_q  <= s2_first_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
`ifdef ADDRESS_AVERAGER_FORWARD_EN
            hold_vld_q  <= hold_vld_d;
            hold_idx_q  <= hold_idx_d;
            hold_dat_q  <= hold_dat_d;
`endif
        end
    end

endmodule

// File: tb/tb_address_averager.sv
// Bench for address_averager: period-level accumulation model, per-cycle output compare, literal result pins.
module tb_address_averager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr;
    logic        tvalid, restart, start;
    logic [13:0] din;
    logic [31:0] n_avg_min;
    logic [7:0]  bram_raddr;
    logic [31:0] bram_rdata;
    logic        bram_wen;
    logic [7:0]  bram_waddr;
    logic [31:0] bram_wdata;
    logic [31:0] n_avg;
    logic        ready;

    always #5 clk = ~clk;

    address_averager #(.WIDTH(8), .DATA_WIDTH(14), .ACC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .tvalid(tvalid), .restart(restart),
        .din(din), .start(start), .n_avg_min(n_avg_min),
        .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .n_avg(n_avg), .ready(ready)
    );

    // Two-cycle-latency BRAM: registered address, registered read data, read-first on collision.
    logic [31:0] mem [0:255];
    logic [7:0]  ra_q;
    logic [31:0] rd_q;
    always @(posedge clk) begin
        ra_q <= bram_raddr;
        rd_q <= mem[ra_q];
        if (bram_wen) mem[bram_waddr] <= bram_wdata;
    end
    assign bram_rdata = rd_q;

    typedef struct {
        int          due;
        logic [7:0]  idx;
        logic [31:0] dat;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] m_mem [0:255];
    logic [31:0] m_navg;
    int          m_ready_at;
    int          cyc;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare();
        chk("raddr", bram_raddr, addr[9:2]);
        while (wq.size() > 0 && wq[0].due < cyc) begin
            chk("missed_write", 0, 1);
            void'(wq.pop_front());
        end
        if (wq.size() > 0 && wq[0].due == cyc) begin
            chk("wen", bram_wen, 1);
            chk("waddr", bram_waddr, wq[0].idx);
            chk("wdata", bram_wdata, wq[0].dat);
            void'(wq.pop_front());
        end else begin
            chk("wen_idle", bram_wen, 0);
        end
        chk("n_avg", n_avg, m_navg);
        chk("ready", ready, (m_ready_at >= 0 && cyc >= m_ready_at));
    endtask

    task automatic tick(input bit inc, input bit clr);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            m_navg     = '0;
            m_ready_at = -1;
        end else if (inc && m_navg != 32'hFFFF_FFFF) begin
            m_navg++;
        end
        start   = 1'b0;
        restart = 1'b0;
        tvalid  = 1'b0;
    endtask

    // One accepted sample: first period overwrites, later periods add, all modulo 2^32.
    task automatic accept(input int w, input int val, input bit first);
        wr_t e;
        if (first) m_mem[w] = 32'(val);
        else       m_mem[w] = m_mem[w] + 32'(val);
        e.due = cyc + 3;
        e.idx = 8'(w);
        e.dat = m_mem[w];
        wq.push_back(e);
    endtask

    task automatic drive(input int w, input int val, input bit rs);
        addr    = {8'(w), 2'(w)};
        din     = 14'(val);
        tvalid  = 1'b1;
        restart = rs;
    endtask

    task automatic period(input int nw, input int val, input bit first, input bit inc);
        for (int w = 0; w < nw; w++) begin
            drive(w, val, w == 0);
            accept(w, val, first);
            tick((w == 0) && inc, 1'b0);
        end
    endtask

    task automatic run_avg(input int nw, input int nmin, input int a, input int b);
        int np;
        int r;
        np        = (nmin == 0) ? 1 : nmin;
        n_avg_min = 32'(nmin);
        start     = 1'b1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(i, 77, 1'b0);
            tick(1'b0, 1'b0);
        end
        for (int p = 0; p < np; p++) period(nw, (p % 2 == 1) ? b : a, p == 0, p > 0);
        drive(0, 55, 1'b1);
        r = cyc;
        tick(1'b1, 1'b0);
        m_ready_at = r + 4;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(i, 11, i != 1);
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic check_mem(input int nw, input logic [31:0] exp, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < nw; i++) if (mem[i] !== exp) bad++;
        chk({nm, "_badwords"}, bad, 0);
        chk({nm, "_last"}, mem[nw-1], exp);
        chk({nm, "_model"}, m_mem[nw-1], exp);
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        cyc        = 0;
        m_navg     = '0;
        m_ready_at = -1;
        rst_n      = 1'b0;
        addr       = '0;
        din        = '0;
        tvalid     = 1'b0;
        restart    = 1'b0;
        start      = 1'b0;
        n_avg_min  = 32'd4;
        #2;
        chk("rst_waddr", bram_waddr, 0);
        chk("rst_wdata", bram_wdata, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 9, 1'b1);
            tick(1'b0, 1'b0);
        end

        run_avg(256, 4, 5, 5);
        chk("navg_final", n_avg, 32'd4);
        check_mem(256, 32'd20, "avg256");

        run_avg(8, 2, 3, -3);
        check_mem(8, 32'd0, "alt");
        run_avg(8, 1, -1, -1);
        check_mem(8, 32'hFFFF_FFFF, "neg1");

        run_avg(8, 2, -16, 32);
        check_mem(8, 32'h0000_0010, "wrap");

        run_avg(8, 0, 4, 4);
        chk("nmin0_navg", n_avg, 32'd1);
        check_mem(8, 32'd4, "nmin0");

        // Abandon a run partway through its third period, then restart it.
        n_avg_min = 32'd10;
        start     = 1'b1;
        tick(1'b0, 1'b1);
        period(8, 7, 1'b1, 1'b0);
        period(8, 7, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            drive(w, 7, w == 0);
            accept(w, 7, 1'b0);
            tick(w == 0, 1'b0);
        end
        chk("midrun_navg", n_avg, 32'd2);
        run_avg(8, 1, 9, 9);
        check_mem(8, 32'd9, "restart");

`ifdef ADDRESS_AVERAGER_FORWARD_EN
        run_avg(2, 8, 1, 1);
        check_mem(2, 32'd8, "fwd2");
        run_avg(1, 3, 2, 2);
        check_mem(1, 32'd6, "fwd1");
`endif

        // Reset with three writes still in the pipeline.
        n_avg_min = 32'd10;
        start     = 1'b1;
        tick(1'b0, 1'b1);
        period(8, 5, 1'b1, 1'b0);
        period(8, 5, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_wen", bram_wen, 0);
        chk("arst_waddr", bram_waddr, 0);
        chk("arst_wdata", bram_wdata, 0);
        chk("arst_navg", n_avg, 0);
        chk("arst_ready", ready, 0);
        wq.delete();
        m_navg     = '0;
        m_ready_at = -1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(i, 3, i[0]);
            tick(1'b0, 1'b0);
        end
        chk("queue_drained", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
